// File: rtl/adc_sample_fifo.sv
// Elastic sample buffer between a non-stalling ADC source and a stallable DMA sink.
// Optional almost_full flag is built only when FIFO_ALMOST_FULL_EN is defined.
module adc_sample_fifo #(
    parameter int unsigned DEPTH_LOG2        = 10,
    parameter int unsigned ALMOST_FULL_LEVEL = 768
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [31:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  clear,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [31:0]           drop_count,
    output logic                  almost_full
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic [31:0]           r_drop_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_level_d;

    // Handshake flags come only from the registered level; no tready-to-tready path.
    assign s_axis_tready = (r_level != LEVEL_FULL);
    assign m_axis_tvalid = (r_level != '0);
    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign level         = r_level;
    assign overflow      = r_overflow;
    assign drop_count    = r_drop_count;

    assign w_push = s_axis_tvalid && s_axis_tready;
    assign w_pop  = m_axis_tvalid && m_axis_tready;
    assign w_drop = s_axis_tvalid && !s_axis_tready;

    always_comb begin
        w_level_d = r_level;
        if (clear) begin
            w_level_d = '0;
        end else if (w_push && !w_pop) begin
            w_level_d = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_d = r_level - 1'b1;
        end
    end

    // Storage carries no reset; stale words are never visible because tvalid gates them.
    always_ff @(posedge aclk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_level <= w_level_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 32'hFFFF_FFFF) begin
                    r_drop_count <= r_drop_count + 32'd1;
                end
            end
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic r_almost_full;

    // Compare against next-state level so the flag lines up with level itself.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_almost_full <= 1'b0;
        end else if (clear) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (32'(w_level_d) >= ALMOST_FULL_LEVEL);
        end
    end

    assign almost_full = r_almost_full;
`else
    logic w_unused_afl;

    assign w_unused_afl = ^ALMOST_FULL_LEVEL;
    assign almost_full  = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed self-checking bench for adc_sample_fifo at DEPTH=16, ALMOST_FULL_LEVEL=12.
module tb_adc_sample_fifo;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        clear;
    logic [4:0]  level;
    logic        overflow;
    logic [31:0] drop_count;
    logic        almost_full;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FIFO_ALMOST_FULL_EN
    localparam bit AfEn = 1'b1;
`else
    localparam bit AfEn = 1'b0;
`endif

    adc_sample_fifo #(
        .DEPTH_LOG2        (4),
        .ALMOST_FULL_LEVEL (12)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .clear         (clear),
        .level         (level),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .almost_full   (almost_full)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance past one active edge; outputs are then sampled and inputs driven.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        clear         = 1'b0;
        #23;
        n_checks++;
        if (level !== 5'd0) begin
            n_fail++; $display("FAIL reset_level: got %0d want 0", level);
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid);
        end
        n_checks++;
        if (overflow !== 1'b0 || drop_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_drop: got ovf=%b cnt=%0d want 0/0", overflow, drop_count);
        end
        n_checks++;
        if (almost_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_af: got %b want 0", almost_full);
        end
        aresetn = 1'b1;
        tick();
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++; $display("FAIL reset_tready: got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_passthrough();
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            s_axis_tdata  = 32'(i);
            s_axis_tvalid = 1'b1;
            tick();
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(i) || level !== 5'd1) begin
                n_fail++;
                $display("FAIL passthrough_%0d: got v=%b d=%h lvl=%0d want v=1 d=%h lvl=1",
                         i, m_axis_tvalid, m_axis_tdata, level, i);
            end
        end
        s_axis_tvalid = 1'b0;
        tick();
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin
            n_fail++; $display("FAIL passthrough_empty: got v=%b lvl=%0d want 0/0", m_axis_tvalid, level);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_overflow_drain();
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata  = 32'h100 + 32'(i);
            s_axis_tvalid = 1'b1;
            tick();
            if (i == 15) begin
                n_checks++;
                if (s_axis_tready !== 1'b0 || level !== 5'd16) begin
                    n_fail++;
                    $display("FAIL fill_full: got rdy=%b lvl=%0d want 0/16", s_axis_tready, level);
                end
                n_checks++;
                if (almost_full !== AfEn) begin
                    n_fail++; $display("FAIL fill_af: got %b want %b", almost_full, AfEn);
                end
            end
        end
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 32'd4) begin
            n_fail++;
            $display("FAIL overflow_cnt: got lvl=%0d ovf=%b cnt=%0d want 16/1/4",
                     level, overflow, drop_count);
        end
        m_axis_tready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h100 + 32'(j)) begin
                n_fail++;
                $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h",
                         j, m_axis_tvalid, m_axis_tdata, 32'h100 + 32'(j));
            end
            tick();
        end
        m_axis_tready = 1'b0;
        n_checks++;
        if (level !== 5'd0 || m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got lvl=%0d v=%b want 0/0", level, m_axis_tvalid);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata  = 32'h200 + 32'(i);
            s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tdata  = 32'hAAAA_AAAA;
        m_axis_tready = 1'b1;
        n_checks++;
        if (m_axis_tdata !== 32'h200 || level !== 5'd16) begin
            n_fail++; $display("FAIL full_pre: got d=%h lvl=%0d want 200/16", m_axis_tdata, level);
        end
        tick();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        n_checks++;
        if (level !== 5'd15 || drop_count !== 32'd5 || m_axis_tdata !== 32'h201) begin
            n_fail++;
            $display("FAIL full_push_pop: got lvl=%0d cnt=%0d d=%h want 15/5/201",
                     level, drop_count, m_axis_tdata);
        end
        m_axis_tready = 1'b1;
        for (int j = 1; j < 16; j++) begin
            n_checks++;
            if (m_axis_tdata !== 32'h200 + 32'(j)) begin
                n_fail++;
                $display("FAIL full_drain_%0d: got %h want %h", j, m_axis_tdata, 32'h200 + 32'(j));
            end
            tick();
        end
        m_axis_tready = 1'b0;
        n_checks++;
        if (level !== 5'd0) begin
            n_fail++; $display("FAIL full_drain_empty: got lvl=%0d want 0", level);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            s_axis_tdata  = 32'h300 + 32'(i);
            s_axis_tvalid = 1'b1;
            tick();
        end
        m_axis_tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            s_axis_tdata = 32'h308 + 32'(c);
            n_checks++;
            if (m_axis_tdata !== 32'h300 + 32'(c) || level !== 5'd8) begin
                n_fail++;
                $display("FAIL b2b_%0d: got d=%h lvl=%0d want d=%h lvl=8",
                         c, m_axis_tdata, level, 32'h300 + 32'(c));
            end
            tick();
        end
        s_axis_tvalid = 1'b0;
        for (int j = 40; j < 48; j++) begin
            n_checks++;
            if (m_axis_tdata !== 32'h300 + 32'(j)) begin
                n_fail++; $display("FAIL b2b_tail_%0d: got %h want %h", j, m_axis_tdata, 32'h300 + 32'(j));
            end
            tick();
        end
        m_axis_tready = 1'b0;
        n_checks++;
        if (level !== 5'd0) begin
            n_fail++; $display("FAIL b2b_empty: got lvl=%0d want 0", level);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if (drop_count !== 32'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL clear_idle: got ovf=%b cnt=%0d want 0/0", overflow, drop_count);
        end
        for (int i = 0; i < 19; i++) begin
            s_axis_tdata  = 32'h400 + 32'(i);
            s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (6) tick();
        m_axis_tready = 1'b0;
        n_checks++;
        if (level !== 5'd10 || overflow !== 1'b1 || drop_count !== 32'd3) begin
            n_fail++;
            $display("FAIL clear_setup: got lvl=%0d ovf=%b cnt=%0d want 10/1/3",
                     level, overflow, drop_count);
        end
        clear         = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tvalid = 1'b1;
        tick();
        clear         = 1'b0;
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (level !== 5'd0 || m_axis_tvalid !== 1'b0 || overflow !== 1'b0 || drop_count !== 32'd0) begin
            n_fail++;
            $display("FAIL clear_push: got lvl=%0d v=%b ovf=%b cnt=%0d want 0/0/0/0",
                     level, m_axis_tvalid, overflow, drop_count);
        end
        s_axis_tdata  = 32'h500;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (level !== 5'd1 || m_axis_tdata !== 32'h500) begin
            n_fail++; $display("FAIL clear_after: got lvl=%0d d=%h want 1/500", level, m_axis_tdata);
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
    endtask

    task automatic test_almost_full();
        for (int i = 0; i < 11; i++) begin
            s_axis_tdata  = 32'h600 + 32'(i);
            s_axis_tvalid = 1'b1;
            tick();
        end
        n_checks++;
        if (almost_full !== 1'b0 || level !== 5'd11) begin
            n_fail++; $display("FAIL af_11: got af=%b lvl=%0d want 0/11", almost_full, level);
        end
        tick();
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (almost_full !== AfEn || level !== 5'd12) begin
            n_fail++; $display("FAIL af_12: got af=%b lvl=%0d want %b/12", almost_full, level, AfEn);
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        n_checks++;
        if (almost_full !== 1'b0 || level !== 5'd11) begin
            n_fail++; $display("FAIL af_pop: got af=%b lvl=%0d want 0/11", almost_full, level);
        end
    endtask

    task automatic test_reset_mid();
        // FIFO holds 11 words from the previous scenario.
        #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || level !== 5'd0 || almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b lvl=%0d af=%b want 0/0/0", m_axis_tvalid, level, almost_full);
        end
        #10;
        aresetn = 1'b1;
        tick();
        n_checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_release: got rdy=%b v=%b want 1/0", s_axis_tready, m_axis_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_overflow_drain();
        test_full_push_pop();
        test_back_to_back();
        test_clear();
        test_almost_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
